// File: rtl/lfm_pulse_seq.sv
// LFM DDS pulse sequencer: per-burst config, start/stop strobe trains gated by output-register READY.
// Optional watchdog on READY waits is compiled in with `define LFM_SEQ_WDOG_EN.
module lfm_pulse_seq #(
  parameter int CNT_W       = 16,
  parameter int NUM_W       = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [CNT_W-1:0] CFG_DURATION,
  input  logic [CNT_W-1:0] CFG_PERIOD,
  input  logic [NUM_W-1:0] CFG_NUM,
  input  logic             ABORT,
  input  logic             OREG_READY,
  output logic             SIGN_START_CALC,
  output logic             SIGN_STOP_CALC,
  output logic             BUSY,
  output logic [NUM_W-1:0] PULSE_IDX,
  output logic             DONE,
  output logic             ERROR
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_START, S_ACTIVE, S_DRAIN, S_GAP, S_FINISH
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] dur_q, per_q, cnt, dur_eff;
  logic [NUM_W-1:0] num_q, idx;
  logic             abort_pend, accept, stop_hit, gap_go, wd_trip;

  assign accept   = CFG_VALID && CFG_READY;
  assign dur_eff  = (dur_q == '0) ? CNT_W'(1) : dur_q;
  assign stop_hit = (state == S_ACTIVE) && ((cnt == dur_eff) || abort_pend);
  // Leave GAP two cycles early so WAIT_RDY -> START lands exactly on t0+PERIOD.
  assign gap_go   = ({1'b0, cnt} + (CNT_W+1)'(2)) >= {1'b0, per_q};

`ifdef LFM_SEQ_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WDOG_CYCLES - 1);
  logic [WD_W-1:0] wd;
  logic            err;

  assign wd_trip = ((state == S_WAIT_RDY) || (state == S_DRAIN)) && !OREG_READY && (wd == WD_LIM);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      if (((state == S_WAIT_RDY) || (state == S_DRAIN)) && !OREG_READY) wd <= wd + WD_W'(1);
      else                                                              wd <= '0;
      if (wd_trip)     err <= 1'b1;
      else if (accept) err <= 1'b0;
    end
  end
  assign ERROR = err;
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES != 0);
  assign wd_trip     = 1'b0;
  assign ERROR       = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (accept) state_n = (CFG_NUM == '0) ? S_FINISH : S_WAIT_RDY;
      S_WAIT_RDY: if (ABORT) state_n = S_FINISH;
                  else if (OREG_READY) state_n = S_START;
      S_START:    state_n = S_ACTIVE;
      S_ACTIVE:   if (stop_hit) state_n = S_DRAIN;
      S_DRAIN:    if (OREG_READY) state_n = (abort_pend || ABORT) ? S_FINISH : S_GAP;
      S_GAP:      if (ABORT || (idx == num_q)) state_n = S_FINISH;
                  else if (gap_go) state_n = S_WAIT_RDY;
      S_FINISH:   state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    if (wd_trip) state_n = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      dur_q      <= '0;
      per_q      <= '0;
      num_q      <= '0;
      idx        <= '0;
      cnt        <= '0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        dur_q      <= CFG_DURATION;
        per_q      <= CFG_PERIOD;
        num_q      <= CFG_NUM;
        idx        <= '0;
        abort_pend <= 1'b0;
      end else begin
        if (stop_hit && (idx != num_q)) idx <= idx + NUM_W'(1);
        if (ABORT && ((state == S_START) || (state == S_ACTIVE) || (state == S_DRAIN)))
          abort_pend <= 1'b1;
      end
      // Period counter: zero during the start cycle, saturates instead of wrapping.
      if (state_n == S_START) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + CNT_W'(1);
    end
  end

  assign CFG_READY       = (state == S_IDLE) && !RESET;
  assign SIGN_START_CALC = (state == S_START) && !RESET;
  assign SIGN_STOP_CALC  = stop_hit && !RESET;
  assign DONE            = (state == S_FINISH) && !RESET;
  assign BUSY            = (state != S_IDLE);
  assign PULSE_IDX       = idx;

endmodule

// File: tb/tb_lfm_pulse_seq.sv
// Scoreboard bench for lfm_pulse_seq: expected strobe cycles are queued at config accept
// and popped as SIGN_START_CALC / SIGN_STOP_CALC / DONE appear.
module tb_lfm_pulse_seq;
  localparam int CNT_W = 16;
  localparam int NUM_W = 8;

  logic             CLK = 1'b0, RESET = 1'b1;
  logic             CFG_VALID = 1'b0, CFG_READY;
  logic [CNT_W-1:0] CFG_DURATION = '0, CFG_PERIOD = '0;
  logic [NUM_W-1:0] CFG_NUM = '0;
  logic             ABORT = 1'b0, OREG_READY = 1'b1;
  logic             SIGN_START_CALC, SIGN_STOP_CALC, BUSY, DONE, ERROR;
  logic [NUM_W-1:0] PULSE_IDX;

  lfm_pulse_seq #(.CNT_W(CNT_W), .NUM_W(NUM_W), .WDOG_CYCLES(64)) dut (
    .CLK(CLK), .RESET(RESET), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_DURATION(CFG_DURATION), .CFG_PERIOD(CFG_PERIOD), .CFG_NUM(CFG_NUM),
    .ABORT(ABORT), .OREG_READY(OREG_READY), .SIGN_START_CALC(SIGN_START_CALC),
    .SIGN_STOP_CALC(SIGN_STOP_CALC), .BUSY(BUSY), .PULSE_IDX(PULSE_IDX),
    .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct { int kind; int cyc; int idx; } ev_t; // kind: 0 start, 1 stop, 2 done
  ev_t q[$];

  int cyc = 0, nchk = 0, nerr = 0, lat = 1, rdy_cnt = 0, ab_cyc = -1, ev_cnt = 0;
  int idx_exp = 0;
  bit idx_pend = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic pop(input int kind);
    ev_t e;
    ev_cnt++;
    if (q.size() == 0) begin
      chk("evt_unexpected", kind + 1, 0);
    end else begin
      e = q.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("evt_cyc", cyc, e.cyc);
      if (kind == 1) begin idx_pend = 1; idx_exp = e.idx; end
    end
  endtask

  // Output-register model: READY drops after a start, returns lat cycles after the stop.
  task automatic drive_ready();
    if (SIGN_START_CALC) OREG_READY = 1'b0;
    if (SIGN_STOP_CALC) rdy_cnt = lat;
    else if (rdy_cnt > 0) begin
      rdy_cnt--;
      if (rdy_cnt == 0) OREG_READY = 1'b1;
    end
  endtask

  always @(negedge CLK) begin
    if (idx_pend) begin chk("pulse_idx", PULSE_IDX, idx_exp); idx_pend = 0; end
    if (SIGN_START_CALC && SIGN_STOP_CALC) chk("start_stop_overlap", 1, 0);
    if (SIGN_START_CALC) pop(0);
    if (SIGN_STOP_CALC)  pop(1);
    if (DONE)            pop(2);
    drive_ready();
    ABORT = (cyc == ab_cyc);
  end

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Drive one config and queue the strobes it should produce.
  task automatic start_burst(input int dur, input int per, input int num, input int l,
                             input int abk, input int abo, input bit no_done);
    int n = 0, a, s, deff, stp, r;
    ev_t e;
    @(negedge CLK);
    while (!CFG_READY && n < 50) begin @(negedge CLK); n++; end
    chk("cfg_ready_wait", CFG_READY, 1);
    lat = l;
    CFG_VALID = 1'b1; CFG_DURATION = CNT_W'(dur); CFG_PERIOD = CNT_W'(per); CFG_NUM = NUM_W'(num);
    a = cyc;
    deff = (dur == 0) ? 1 : dur;
    s = a + 2;
    if (num == 0) begin e = '{2, a + 1, 0}; q.push_back(e); end
    for (int k = 0; k < num; k++) begin
      e = '{0, s, 0}; q.push_back(e);
      stp = s + deff;
      if (k == abk) begin
        ab_cyc = s + abo;
        if (abo + 1 < deff) stp = s + abo + 1;
      end
      e = '{1, stp, k + 1}; q.push_back(e);
      r = stp + lat;
      if (k == abk) begin e = '{2, r + 1, 0}; q.push_back(e); break; end
      if (k == num - 1) begin
        if (!no_done) begin e = '{2, r + 2, 0}; q.push_back(e); end
      end else s = imax(s + per, r + 3);
    end
    @(negedge CLK);
    CFG_VALID = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 3000) begin @(negedge CLK); n++; end
    chk(tag, q.size(), 0);
    repeat (2) @(negedge CLK);
    chk("idle_busy", BUSY, 0);
    chk("idle_cfg_ready", CFG_READY, 1);
    ab_cyc = -1;
  endtask

  initial begin
    int ev0;
    repeat (3) @(negedge CLK);
    chk("rst_cfg_ready", CFG_READY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_idx", PULSE_IDX, 0);
    chk("rst_err", ERROR, 0);
    chk("rst_strobes", {SIGN_START_CALC, SIGN_STOP_CALC, DONE}, 0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_cfg_ready", CFG_READY, 1);

    start_burst(4, 10, 3, 3, -1, 0, 0);  wait_drain("sb_basic");
    start_burst(0, 2, 2, 2, -1, 0, 0);   wait_drain("sb_dur0_slip");
    start_burst(5, 3, 2, 1, -1, 0, 0);   wait_drain("sb_per_le_dur");
    start_burst(7, 9, 0, 1, -1, 0, 0);   wait_drain("sb_num0");
    start_burst(8, 12, 5, 3, 1, 2, 0);   wait_drain("sb_abort_active");
    start_burst(6, 12, 3, 2, 0, 0, 0);   wait_drain("sb_abort_start");
    start_burst(3, 8, 2, 2, 1, 3, 0);    wait_drain("sb_abort_on_stop");

    // Reset while a pulse is active.
    start_burst(8, 20, 3, 2, -1, 0, 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("rst_mid_strobes", {SIGN_START_CALC, SIGN_STOP_CALC, DONE}, 0);
    @(negedge CLK);
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_idx", PULSE_IDX, 0);
    q.delete(); idx_pend = 0; rdy_cnt = 0; OREG_READY = 1'b1;
    RESET = 1'b0;
    ev0 = ev_cnt;
    repeat (20) @(negedge CLK);
    chk("rst_mid_no_events", ev_cnt - ev0, 0);

`ifdef LFM_SEQ_WDOG_EN
    start_burst(3, 10, 1, 1000, -1, 0, 1);
    repeat (100) @(negedge CLK);
    chk("wdog_err", ERROR, 1);
    chk("wdog_busy", BUSY, 0);
    chk("wdog_no_done", q.size(), 0);
    rdy_cnt = 0; OREG_READY = 1'b1;
    start_burst(2, 6, 1, 2, -1, 0, 0);
    chk("wdog_err_clear", ERROR, 0);
    wait_drain("sb_after_wdog");
`else
    start_burst(3, 10, 1, 150, -1, 0, 0);
    repeat (80) @(negedge CLK);
    chk("nowdog_err", ERROR, 0);
    chk("nowdog_busy", BUSY, 1);
    wait_drain("sb_long_wait");
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 want 0");
    $fatal(1, "timeout");
  end
endmodule
